// File: rtl/fifo_ctrl_if.sv
// Bundle of the FIFO-bank control signals: configuration requests, per-FIFO status in,
// and the applied thresholds and controller status out.
interface fifo_ctrl_if #(
  parameter int NUM_FIFOS = 8,
  parameter int PTR       = 3
);
  logic                 init;
  logic [PTR-1:0]       full_threshold;
  logic [PTR-1:0]       empty_threshold;
  logic [NUM_FIFOS-1:0] fifos_empty;
  logic [NUM_FIFOS-1:0] fifos_error;
  logic                 err_clear;
  logic [PTR-1:0]       fifos_full_threshold;
  logic [PTR-1:0]       fifos_empty_threshold;
  logic                 idle;
  logic                 error;
  logic [NUM_FIFOS-1:0] error_fifo;
  logic                 cfg_invalid;
  logic [2:0]           state;

  modport master (
    output init, full_threshold, empty_threshold, fifos_empty, fifos_error, err_clear,
    input  fifos_full_threshold, fifos_empty_threshold, idle, error, error_fifo,
           cfg_invalid, state
  );

  modport slave (
    input  init, full_threshold, empty_threshold, fifos_empty, fifos_error, err_clear,
    output fifos_full_threshold, fifos_empty_threshold, idle, error, error_fifo,
           cfg_invalid, state
  );
endinterface

// File: rtl/fifo_ctrl_fsm.sv
// Control FSM for the switch FIFO bank: threshold configuration, idle debounce and
// sticky error trapping.
//
// state  | meaning
// RESET  | just out of reset, moves to INIT
// INIT   | accepting threshold configuration
// IDLE   | configured, every FIFO empty
// ACTIVE | traffic present, debouncing the return to idle
// ERROR  | overflow/underflow trapped, waiting for err_clear
module fifo_ctrl_fsm #(
  parameter int NUM_FIFOS = 8,
  parameter int PTR       = 3,
  parameter int IDLE_DLY  = 4
) (
  input logic        clk,
  input logic        reset,
  fifo_ctrl_if.slave bus
);
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam int              CW       = $clog2(IDLE_DLY + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(IDLE_DLY - 1);

  logic [2:0]           state_q, state_d;
  logic [PTR-1:0]       full_thr_q, full_thr_d;
  logic [PTR-1:0]       empty_thr_q, empty_thr_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic [CW-1:0]        empty_cnt_q, empty_cnt_d;
  logic [NUM_FIFOS-1:0] error_fifo_q, error_fifo_d;
  logic                 cfg_invalid_q, cfg_invalid_d;
  logic                 idle_q, idle_d;
  logic                 error_q, error_d;

  logic all_empty, any_err, cfg_ok;

  assign all_empty = &bus.fifos_empty;
  assign any_err   = |bus.fifos_error;
  assign cfg_ok    = bus.full_threshold > bus.empty_threshold;

  always_comb begin
    state_d       = state_q;
    full_thr_d    = full_thr_q;
    empty_thr_d   = empty_thr_q;
    cfg_valid_d   = cfg_valid_q;
    empty_cnt_d   = '0;
    error_fifo_d  = error_fifo_q;
    cfg_invalid_d = 1'b0;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (bus.init) begin
          if (cfg_ok) begin
            full_thr_d  = bus.full_threshold;
            empty_thr_d = bus.empty_threshold;
            cfg_valid_d = 1'b1;
          end else begin
            cfg_invalid_d = 1'b1;
          end
        end else if (cfg_valid_q) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        error_fifo_d = error_fifo_q | bus.fifos_error;
        if (any_err)        state_d = S_ERROR;
        else if (bus.init)  state_d = S_INIT;
        else if (!all_empty) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        error_fifo_d = error_fifo_q | bus.fifos_error;
        if (any_err) begin
          state_d = S_ERROR;
        end else if (all_empty) begin
          // the counter only ever reaches IDLE_DLY-1, so it cannot wrap
          if (empty_cnt_q == CNT_LAST) state_d = S_IDLE;
          else                         empty_cnt_d = empty_cnt_q + CW'(1);
        end
      end
      S_ERROR: begin
        if (bus.err_clear) begin
          error_fifo_d = '0;
          state_d      = S_INIT;
        end else begin
          error_fifo_d = error_fifo_q | bus.fifos_error;
        end
      end
      default: state_d = S_RESET;
    endcase
    idle_d  = (state_d == S_IDLE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_RESET;
      full_thr_q    <= '0;
      empty_thr_q   <= '0;
      cfg_valid_q   <= 1'b0;
      empty_cnt_q   <= '0;
      error_fifo_q  <= '0;
      cfg_invalid_q <= 1'b0;
      idle_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_thr_q    <= full_thr_d;
      empty_thr_q   <= empty_thr_d;
      cfg_valid_q   <= cfg_valid_d;
      empty_cnt_q   <= empty_cnt_d;
      error_fifo_q  <= error_fifo_d;
      cfg_invalid_q <= cfg_invalid_d;
      idle_q        <= idle_d;
      error_q       <= error_d;
    end
  end

  assign bus.state                 = state_q;
  assign bus.fifos_full_threshold  = full_thr_q;
  assign bus.fifos_empty_threshold = empty_thr_q;
  assign bus.idle                  = idle_q;
  assign bus.error                 = error_q;
  assign bus.error_fifo            = error_fifo_q;
  assign bus.cfg_invalid           = cfg_invalid_q;
endmodule

// File: doc/fifo_ctrl_fsm.md
# fifo_ctrl_fsm

Parametrised control state machine for the switch FIFO bank. It latches and validates the full/empty threshold configuration and tracks traffic activity across `NUM_FIFOS` FIFOs. It debounces the return to idle over a programmable number of cycles and traps FIFO overflow/underflow errors in a sticky error state. It sits beside the FIFO bank and drives the threshold inputs of every FIFO plus the bank-level `idle` flag.

## Interface

- `NUM_FIFOS`, 8, number of monitored FIFOs.
- `PTR`, 3, threshold width (log2 of FIFO depth).
- `IDLE_DLY`, 4, consecutive all-empty samples in ACTIVE required before IDLE (≥1).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `init`  in  1  configuration request.
- `full_threshold`  in  PTR  requested almost-full threshold.
- `empty_threshold`  in  PTR  requested almost-empty threshold.
- `fifos_empty`  in  NUM_FIFOS  per-FIFO empty flags.
- `fifos_error`  in  NUM_FIFOS  per-FIFO overflow/underflow pulses.
- `err_clear`  in  1  leaves ERROR.
- `fifos_full_threshold`  out  PTR  applied almost-full threshold.
- `fifos_empty_threshold`  out  PTR  applied almost-empty threshold.
- `idle`  out  1  high while state is IDLE.
- `error`  out  1  high while state is ERROR.
- `error_fifo`  out  NUM_FIFOS  sticky record of erroring FIFOs.
- `cfg_invalid`  out  1  one-cycle pulse on a rejected configuration.
- `state`  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.

## Operation

- `reset`=0 at an edge:
  - `state`=RESET.
  - All outputs 0.
  - Internal `cfg_valid`=0 and `empty_cnt`=0.
- Configuration is valid iff `full_threshold > empty_threshold` (unsigned, PTR bits); full=0 is therefore always invalid.
- RESET → INIT unconditionally.
- INIT, `init`=1, valid configuration:
  - Latch both thresholds and set `cfg_valid`.
  - Stay INIT.
- INIT, `init`=1, invalid configuration:
  - Thresholds hold their previous values.
  - `cfg_invalid`=1 for that cycle.
  - Stay INIT.
- INIT, `init`=0: go to IDLE if `cfg_valid`, otherwise stay INIT.
- IDLE, in priority order:
  - Any `fifos_error` bit → ERROR.
  - Else `init` → INIT.
  - Else any `fifos_empty` bit 0 → ACTIVE.
  - Else stay IDLE.
- ACTIVE:
  - Any `fifos_error` bit → ERROR.
  - `init` is ignored.
  - Each all-ones `fifos_empty` sample increments `empty_cnt`; any zero bit clears it.
  - The all-ones sample made when `empty_cnt == IDLE_DLY-1` → IDLE, with `empty_cnt` cleared.
- ERROR:
  - `init` is ignored.
  - `err_clear`=1 → INIT, clearing `error_fifo`; thresholds and `cfg_valid` are retained.
  - Without `err_clear`, stay ERROR.
- `error_fifo |= fifos_error` every cycle in IDLE, ACTIVE and ERROR. The clear on exit from ERROR takes precedence over same-cycle accumulation.
- `empty_cnt` is `$clog2(IDLE_DLY+1)` bits wide, cleared whenever state is not ACTIVE, and never wraps.

## Timing

- All outputs are registered and change on the same edge as `state`; `idle`/`error` reflect the next state.
- Latency is one cycle from a sampled input to the state/output change.
- Thresholds update on the edge after `init` is sampled with a valid configuration.
- ACTIVE → IDLE needs `IDLE_DLY` consecutive all-empty samples. With `IDLE_DLY`=1 it leaves on the first all-empty sample.
- A single-cycle `fifos_error` pulse is sufficient to trap.
- `reset` mid-operation takes effect at the next edge, regardless of state.

## Test plan

- Reset; `init`=1 with full=6, empty=2 for 2 cycles, then `init`=0:
  - State sequence 0 → 1 → 1 → 2.
  - Thresholds read 6/2 from the first latch edge.
  - `idle`=1 on entering IDLE.
- From reset, `init`=1 with full=2, empty=5, then `init`=0:
  - `cfg_invalid` pulses high.
  - Thresholds stay 0/0.
  - State remains INIT.
  - A later valid full=7, empty=1 latches and reaches IDLE.
- `IDLE_DLY`=4, IDLE:
  - `fifos_empty`=0xFE → ACTIVE next edge, `idle`=0.
  - Then 0xFF, 0xFF, 0xFB, then 0xFF ×4 → IDLE only on the 4th 0xFF after 0xFB.
- ACTIVE, `fifos_error`=0x08 for one cycle with `init`=1:
  - ERROR, `error`=1, `error_fifo`=0x08.
  - A later 0x01 pulse gives 0x09.
  - `err_clear`=1 → INIT, `error_fifo`=0, thresholds unchanged.
- IDLE, `init`=1 together with `fifos_error`=0x02 → ERROR, not INIT.
- `reset`=0 asserted while in ACTIVE with `error_fifo`≠0 → next edge all outputs 0 and `state`=0.
